ks_adder_pipe: RTL and testbench
================================

Name: ks_adder_pipe

Overview:
Parametrised, pipelined Kogge-Stone adder/subtractor that generalises the team's fixed 32-bit combinational KS adder. It has configurable width, one register stage per prefix level, a per-operation add/sub mode, and signed-overflow detection. A valid/ready handshake on both sides allows full-throughput streaming with backpressure. It sits in datapaths that need 1 result/cycle at high clock rates.

Parameters:
WIDTH, 32, operand width in bits; must be ≥2.
LEVELS, $clog2(WIDTH), number of prefix levels; derived, not overridden.
LAT, LEVELS+2, pipeline latency in cycles; derived (P/G stage + LEVELS prefix stages + sum stage).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_cin  in  1  carry-in; used only when in_sub=0.
in_sub  in  1  0: A+B+cin; 1: A−B (A+~B+1, cin ignored).
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_sum  out  WIDTH  sum/difference.
out_cout  out  1  carry out of MSB (for sub: 1 = no borrow).
out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-stream): all stage valid flags, out_valid, out_sum, out_cout and out_ovf go to 0 immediately. In-flight beats are discarded. in_ready=1 from the first cycle after release.
- Stage 0 registers, on accept: p=a^b', g=a&b' (b' = sub ? ~b : b); c0 = sub ? 1 : cin; also original p for the sum.
- Carry-in handling: c0 is folded in as generate into bit 0 (g0 |= p0&c0).
- Stages 1..LEVELS: level k combines span 2^(k−1). For i ≥ span: G=g_i | p_i&g_(i−span), P=p_i&p_(i−span). Lower bits pass through. Each level is registered.
- Final stage: sum_i = p_i ^ carry_(i−1), where carry_(−1)=c0. cout=G_(WIDTH−1). ovf = carry_(WIDTH−2) ^ cout. Registered into out_*.
- Latency: a beat accepted at edge N appears on out_valid/out_sum after edge N+LAT−1, i.e. visible LAT cycles after acceptance, when unstalled. WIDTH=32 → LAT=7.
- Handshake: transfer occurs when valid&&ready at a rising edge. Each stage s holds valid flag v[s]. Stage s loads when !v[s] || stage s+1 advancing; the last stage advances when out_ready.
- in_ready = !v[0] || stage 0 advancing. This is a combinational ready chain; there are no bubbles.
- Throughput 1 beat/cycle with out_ready=1. Capacity LAT beats when out_ready=0. Order is preserved.
- out_* hold stable while out_valid=1 and out_ready=0.
- Beats offered while in_ready=0 are not taken; the source must hold them.
- Simultaneous accept on the input and drain on the output when full: both occur and occupancy is unchanged.
- Wrap-around: sum is modulo 2^WIDTH; cout carries the extra bit.

Test Plan:
- Add, WIDTH=32: a=631ff211, b=12356312, cin=0, sub=0 → sum=75555523, cout=0, ovf=0, out_valid exactly 7 cycles after accept.
- Extremes: a=b=ffffffff, cin=1 → sum=ffffffff, cout=1, ovf=0. a=7fffffff, b=1, cin=0 → sum=80000000, cout=0, ovf=1.
- Subtract: sub=1, a=0, b=1 → sum=ffffffff, cout=0. sub=1, a=80000000, b=1 → sum=7fffffff, cout=1, ovf=1. in_cin=1 is ignored in both.
- Backpressure: out_ready=0, offer 8 consecutive beats → exactly 7 accepted, in_ready=0 thereafter. Raise out_ready → 7 results in order, back-to-back, then the 8th.
- Streaming: 100 random beats with out_ready=1, in_valid=1 → in_ready never drops, 1 result/cycle, all match the reference model. Repeat with random out_ready → no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 4 beats in flight → outputs zero asynchronously. After release no stale result appears and the first new beat returns after 7 cycles. Also rerun the add scenario at WIDTH=8 and WIDTH=13 (LAT=5 and 6).

Source files
------------

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready streaming.
// One register stage for P/G, one per prefix level, one for the sum.
module ks_adder_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = LEVELS + 2;

    logic [LAT-1:0] v;
    logic [LAT-1:0] ld;

    logic [WIDTH-1:0] pr  [LEVELS];
    logic [WIDTH-1:0] pn  [LEVELS];
    logic [WIDTH-1:0] gr  [LEVELS+1];
    logic [WIDTH-1:0] gn  [LEVELS+1];
    logic [WIDTH-1:0] por [LEVELS+1];
    logic [LEVELS:0]  c0r;

    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_n;

    // A stage may load when it or any later stage has a free slot,
    // or the consumer drains the last stage this cycle.
    for (genvar s = 0; s < LAT; s++) begin : g_ld
        assign ld[s] = out_ready | ~(&v[LAT-1:s]);
    end

    assign in_ready  = ld[0];
    assign out_valid = v[LAT-1];

    assign bx    = in_sub ? ~in_b : in_b;
    assign c0    = in_sub | in_cin;
    assign pn[0] = in_a ^ bx;
    assign gn[0] = (in_a & bx)
                 | {{(WIDTH-1){1'b0}}, pn[0][0] & c0};

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int SP = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SP) begin : g_hi
                assign gn[k][i] = gr[k-1][i]
                                | (pr[k-1][i] & gr[k-1][i-SP]);
                if (k < LEVELS) begin : g_p
                    assign pn[k][i] = pr[k-1][i] & pr[k-1][i-SP];
                end
            end else begin : g_lo
                assign gn[k][i] = gr[k-1][i];
                if (k < LEVELS) begin : g_p
                    assign pn[k][i] = pr[k-1][i];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k]   <= 1'b0;
                gr[k]  <= '0;
                por[k] <= '0;
                c0r[k] <= 1'b0;
            end else if (ld[k]) begin
                v[k] <= v[k-1];
                if (v[k-1]) begin
                    gr[k]  <= gn[k];
                    por[k] <= por[k-1];
                    c0r[k] <= c0r[k-1];
                end
            end
        end

        if (k < LEVELS) begin : g_preg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pr[k] <= '0;
                end else if (ld[k] && v[k-1]) begin
                    pr[k] <= pn[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v[0]   <= 1'b0;
            pr[0]  <= '0;
            gr[0]  <= '0;
            por[0] <= '0;
            c0r[0] <= 1'b0;
        end else if (ld[0]) begin
            v[0] <= in_valid;
            if (in_valid) begin
                pr[0]  <= pn[0];
                gr[0]  <= gn[0];
                por[0] <= pn[0];
                c0r[0] <= c0;
            end
        end
    end

    // After the last level gr holds the carry out of every bit position.
    assign carry = {gr[LEVELS][WIDTH-2:0], c0r[LEVELS]};
    assign sum_n = por[LEVELS] ^ carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v[LAT-1] <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (ld[LAT-1]) begin
            v[LAT-1] <= v[LAT-2];
            if (v[LAT-2]) begin
                out_sum  <= sum_n;
                out_cout <= gr[LEVELS][WIDTH-1];
                out_ovf  <= gr[LEVELS][WIDTH-2] ^ gr[LEVELS][WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Randomised and directed bench for ks_adder_pipe against an
// arithmetic reference model (WIDTH 32, plus 8 and 13 for latency).
module tb_ks_adder_pipe;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [31:0] out_sum;

    logic        sv;
    logic [31:0] sa, sb;
    logic        rdy8, ov8, oc8, oo8;
    logic [7:0]  os8;
    logic        rdy13, ov13, oc13, oo13;
    logic [12:0] os13;

    always #5 clk = ~clk;

    ks_adder_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    ks_adder_pipe #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sv), .in_ready(rdy8),
        .in_a(sa[7:0]), .in_b(sb[7:0]), .in_cin(1'b0), .in_sub(1'b0),
        .out_valid(ov8), .out_ready(1'b1),
        .out_sum(os8), .out_cout(oc8), .out_ovf(oo8)
    );

    ks_adder_pipe #(.WIDTH(13)) d13 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sv), .in_ready(rdy13),
        .in_a(sa[12:0]), .in_b(sb[12:0]), .in_cin(1'b0), .in_sub(1'b0),
        .out_valid(ov13), .out_ready(1'b1),
        .out_sum(os13), .out_cout(oc13), .out_ovf(oo13)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_in  = 0;
    int n_out = 0;
    logic [33:0] q[$];

    logic [31:0] ba, bb;
    logic        bcin, bsub;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum} from plain integer arithmetic on w-bit operands.
    function automatic logic [33:0] ref_m(input int w, input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] m, aa, bv, s;
        logic        co, ov;
        m  = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & m;
        bv = (sub ? ~{32'd0, b} : {32'd0, b}) & m;
        s  = aa + bv + ((sub || cin) ? 64'd1 : 64'd0);
        co = s[w];
        ov = (aa[w-1] == bv[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s[31:0] & m[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'hffff_ffff;
            1: return 32'h7fff_ffff;
            2: return 32'h8000_0000;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic new_beat();
        ba   = pick();
        bb   = pick();
        bcin = 1'($urandom_range(0, 1));
        bsub = 1'($urandom_range(0, 1));
    endtask

    task automatic step(input logic iv, input logic ordy,
                        output logic fi, output logic fo);
        @(negedge clk);
        in_valid  = iv;
        in_a      = ba;
        in_b      = bb;
        in_cin    = bcin;
        in_sub    = bsub;
        out_ready = ordy;
        #1;
        fi = in_valid && in_ready;
        fo = out_valid && out_ready;
        if (fo) begin
            n_out++;
            if (q.size() == 0) check("sb_extra", 1, 0);
            else check("sb_data", {out_ovf, out_cout, out_sum}, q.pop_front());
        end
        if (fi) begin
            n_in++;
            q.push_back(ref_m(32, ba, bb, bcin, bsub));
        end
    endtask

    task automatic dir(input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub,
                       input logic [31:0] es, input logic ec,
                       input logic eo);
        logic fi, fo;
        int   lat;
        ba = a; bb = b; bcin = cin; bsub = sub;
        step(1'b1, 1'b1, fi, fo);
        check("dir_accept", fi, 1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(1'b0, 1'b1, fi, fo);
            if (out_valid) begin
                lat = i;
                check("dir_sum", out_sum, es);
                check("dir_cout", out_cout, ec);
                check("dir_ovf", out_ovf, eo);
            end
        end
        check("dir_latency", lat, LAT);
    endtask

    task automatic small_run(input logic [31:0] a, input logic [31:0] b);
        int          l8, l13;
        logic [33:0] r8, r13;
        l8 = 0; l13 = 0; r8 = '0; r13 = '0;
        @(negedge clk);
        sa = a; sb = b; sv = 1'b1;
        #1;
        check("w8_ready", rdy8, 1);
        check("w13_ready", rdy13, 1);
        @(negedge clk);
        sv = 1'b0;
        #1;
        for (int i = 1; i <= 12; i++) begin
            if (ov8 && l8 == 0) begin
                l8 = i; r8 = {oo8, oc8, 24'd0, os8};
            end
            if (ov13 && l13 == 0) begin
                l13 = i; r13 = {oo13, oc13, 19'd0, os13};
            end
            @(negedge clk);
            #1;
        end
        check("w8_latency", l8, 5);
        check("w13_latency", l13, 6);
        check("w8_result", r8, ref_m(8, a, b, 1'b0, 1'b0));
        check("w13_result", r13, ref_m(13, a, b, 1'b0, 1'b0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic        fi, fo, pend;
        logic [33:0] held;
        int          acc, outs, drops, i0, o0, stale;

        in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0;
        out_ready = 0; sv = 0; sa = 0; sb = 0;
        ba = 0; bb = 0; bcin = 0; bsub = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_out", {out_ovf, out_cout, out_sum}, 0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", in_ready, 1);

        dir(32'h631f_f211, 32'h1235_6312, 0, 0, 32'h7555_5523, 0, 0);
        dir(32'hffff_ffff, 32'hffff_ffff, 1, 0, 32'hffff_ffff, 1, 0);
        dir(32'h7fff_ffff, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
        dir(32'h0000_0000, 32'h0000_0001, 1, 1, 32'hffff_ffff, 0, 0);
        dir(32'h8000_0000, 32'h0000_0001, 1, 1, 32'h7fff_ffff, 1, 1);

        // fill with the consumer stalled
        new_beat();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, fi, fo);
            if (fi) begin acc++; new_beat(); end
        end
        check("bp_accepted", acc, LAT);
        step(1'b1, 1'b0, fi, fo);
        check("bp_stall_ready", fi, 0);
        check("bp_out_valid", out_valid, 1);
        held = {out_ovf, out_cout, out_sum};
        step(1'b1, 1'b0, fi, fo);
        check("bp_hold", {out_ovf, out_cout, out_sum}, held);
        pend = 1'b1;
        outs = 0;
        for (int i = 0; i < 8; i++) begin
            step(pend, 1'b1, fi, fo);
            if (fi) pend = 1'b0;
            if (fo) outs++;
        end
        check("bp_drain", outs, 8);
        check("bp_empty", q.size(), 0);

        // full-rate streaming
        new_beat();
        drops = 0; outs = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, fi, fo);
            if (!fi) drops++;
            else new_beat();
            if (fo) outs++;
        end
        check("st_ready_drop", drops, 0);
        check("st_rate", outs, 100 - LAT);
        for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 1'b1, fi, fo);
        check("st_empty", q.size(), 0);

        // random valid / ready
        i0 = n_in; o0 = n_out;
        new_beat();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fi, fo);
            if (fi) new_beat();
        end
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, 1'b1, fi, fo);
        check("rnd_count", n_out - o0, n_in - i0);
        check("rnd_empty", q.size(), 0);

        // reset with beats in flight
        ba = 32'd1; bb = 32'd1; bcin = 0; bsub = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, fi, fo);
            new_beat();
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, fi, fo);
        check("mid_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_out", {out_ovf, out_cout, out_sum}, 0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, fi, fo);
            if (out_valid) stale++;
        end
        check("mid_no_stale", stale, 0);
        dir(32'h631f_f211, 32'h1235_6312, 0, 0, 32'h7555_5523, 0, 0);

        small_run(32'h631f_f211, 32'h1235_6312);
        small_run($urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
